// File: rtl/pam4_frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// pam4_frame_seq_pkg
//   Shared definitions for the PAM4 frame sequencer.
//   - seq_state_e : FSM states IDLE=0, PREAMBLE=1, PAYLOAD=2, GAP=3
//   - PAM4_L0..L3 : PAM4 level indices, lowest to highest
//   - PRBS7_TAP_* : tap positions of the x^7+x^6+1 Fibonacci LFSR
//   - CNT_W       : width of the shared phase counter
//   - pam4_gray() : natural-to-Gray level mapping for the optional output stage
// -----------------------------------------------------------------------------
package pam4_frame_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_GAP      = 2'd3
   } seq_state_e;

   localparam logic [1:0] PAM4_L0 = 2'b00;
   localparam logic [1:0] PAM4_L1 = 2'b01;
   localparam logic [1:0] PAM4_L2 = 2'b10;
   localparam logic [1:0] PAM4_L3 = 2'b11;

   localparam int unsigned PRBS7_TAP_HI = 6;
   localparam int unsigned PRBS7_TAP_LO = 5;

   localparam int unsigned CNT_W = 9;

   function automatic logic [1:0] pam4_gray(input logic [1:0] b);
      return b ^ {1'b0, b[1]};
   endfunction

endpackage

// File: rtl/pam4_frame_seq_prbs7_lfsr.sv
// -----------------------------------------------------------------------------
// prbs7_lfsr
//   PRBS7 generator (x^7+x^6+1, Fibonacci). Advances two steps per request so
//   one PAM4 symbol consumes two fresh bits.
//   Ports:
//     clk    in   system clock
//     g_rst  in   async active-high reset, register returns to RST_SEED
//     load   in   reload register from seed (wins over step2)
//     step2  in   advance the register by two LFSR steps
//     seed   in   7-bit reload value
//     sym    out  current symbol {l[6], l[5]}
// -----------------------------------------------------------------------------
module prbs7_lfsr
   import pam4_frame_seq_pkg::*;
#(
   parameter logic [6:0] RST_SEED = 7'h7F
) (
   input  logic       clk,
   input  logic       g_rst,
   input  logic       load,
   input  logic       step2,
   input  logic [6:0] seed,
   output logic [1:0] sym
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;
   logic       fb1;
   logic       fb2;

   // Two single steps folded together: the second feedback uses the taps
   // shifted down by one, which are still inside the current register.
   always_comb begin
      fb1    = lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO];
      fb2    = lfsr_q[PRBS7_TAP_HI - 1] ^ lfsr_q[PRBS7_TAP_LO - 1];
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = seed;
      end else if (step2) begin
         lfsr_d = {lfsr_q[4:0], fb1, fb2};
      end
   end

   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) begin
         lfsr_q <= RST_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign sym = {lfsr_q[PRBS7_TAP_HI], lfsr_q[PRBS7_TAP_LO]};

endmodule

// File: rtl/pam4_frame_seq.sv
// -----------------------------------------------------------------------------
// pam4_frame_seq
//   Waits for one complete slow_rst pulse, then streams PAM4 frames over
//   valid/ready: alternating preamble, reseeded PRBS7 payload, idle gap.
//   Ports:
//     clk        in   system clock
//     g_rst      in   async active-high global reset
//     slow_rst   in   slow reset pulse, synchronous to clk
//     sym_ready  in   downstream accepts on sym_valid & sym_ready
//     sym_valid  out  sym_data is valid
//     sym_data   out  PAM4 level index (00 lowest .. 11 highest)
//     sym_sof    out  first preamble symbol of a frame
//     busy       out  FSM in PREAMBLE, PAYLOAD or GAP
//   Build option: define PAM4_GRAY_EN to Gray-code sym_data; timing unchanged.
// -----------------------------------------------------------------------------
module pam4_frame_seq
   import pam4_frame_seq_pkg::*;
#(
   parameter int unsigned PREAMBLE_LEN = 32,
   parameter int unsigned PAYLOAD_LEN  = 256,
   parameter int unsigned GAP_LEN      = 8,
   parameter logic [6:0]  PRBS_SEED    = 7'h7F
) (
   input  logic       clk,
   input  logic       g_rst,
   input  logic       slow_rst,
   input  logic       sym_ready,
   output logic       sym_valid,
   output logic [1:0] sym_data,
   output logic       sym_sof,
   output logic       busy
);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

   seq_state_e       state_q;
   logic             armed_q;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q;
   logic             sof_q;
   logic             busy_q;

   logic             accept;
   logic             lfsr_load;
   logic             lfsr_step2;
   logic [1:0]       prbs_sym;
   logic [1:0]       sym_nat;

   assign accept     = valid_q & sym_ready;
   // Reseed on every slow_rst and on the preamble->payload handover, so each
   // payload starts from PRBS_SEED regardless of history.
   assign lfsr_load  = slow_rst |
                       ((state_q == ST_PREAMBLE) & accept & (cnt_q == PRE_LAST));
   assign lfsr_step2 = (state_q == ST_PAYLOAD) & accept;

   prbs7_lfsr #(
      .RST_SEED (PRBS_SEED)
   ) u_lfsr (
      .clk   (clk),
      .g_rst (g_rst),
      .load  (lfsr_load),
      .step2 (lfsr_step2),
      .seed  (PRBS_SEED),
      .sym   (prbs_sym)
   );

   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (slow_rst) begin
         // Also arms: the low period before the first pulse is ignored.
         state_q <= ST_IDLE;
         armed_q <= 1'b1;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (armed_q) begin
                  state_q <= ST_PREAMBLE;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  sof_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_PREAMBLE: begin
               if (accept) begin
                  sof_q <= 1'b0;
                  if (cnt_q == PRE_LAST) begin
                     state_q <= ST_PAYLOAD;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  if (cnt_q == PAY_LAST) begin
                     state_q <= ST_GAP;
                     cnt_q   <= '0;
                     valid_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q <= ST_PREAMBLE;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  sof_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Symbol derives from held registers only, so it stays stable during stalls.
   always_comb begin
      sym_nat = PAM4_L0;
      case (state_q)
         ST_PREAMBLE: sym_nat = cnt_q[0] ? PAM4_L3 : PAM4_L0;
         ST_PAYLOAD:  sym_nat = prbs_sym;
         default:     sym_nat = PAM4_L0;
      endcase
   end

`ifdef PAM4_GRAY_EN
   assign sym_data = pam4_gray(sym_nat);
`else
   assign sym_data = sym_nat;
`endif

   assign sym_valid = valid_q;
   assign sym_sof   = sof_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pam4_frame_seq.sv
module tb_pam4_frame_seq;

   localparam int PRE   = 32;
   localparam int PAY   = 256;
   localparam int GAP   = 8;
   localparam int FRAME = PRE + PAY + GAP;

   logic       clk = 1'b0;
   logic       g_rst;
   logic       slow_rst;
   logic       sym_ready;
   logic       sym_valid;
   logic [1:0] sym_data;
   logic       sym_sof;
   logic       busy;

   int vectors = 0;
   int errors  = 0;

   // Reference model: position within the frame timeline. Positions
   // 0..PRE+PAY-1 are symbols (advance on accept), the rest are gap cycles.
   bit         m_run;
   bit         m_armed;
   int         m_pos;
   logic [1:0] pay_sym [PAY];

   pam4_frame_seq #(
      .PREAMBLE_LEN (PRE),
      .PAYLOAD_LEN  (PAY),
      .GAP_LEN      (GAP),
      .PRBS_SEED    (7'h7F)
   ) dut (
      .clk       (clk),
      .g_rst     (g_rst),
      .slow_rst  (slow_rst),
      .sym_ready (sym_ready),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_sof   (sym_sof),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] map_sym(input logic [1:0] b);
`ifdef PAM4_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   function automatic logic e_valid();
      return m_run && (m_pos < PRE + PAY);
   endfunction

   function automatic logic e_busy();
      return m_run;
   endfunction

   function automatic logic e_sof();
      return m_run && (m_pos == 0);
   endfunction

   function automatic logic [1:0] e_data();
      if (!e_valid()) return 2'b00;
      if (m_pos < PRE) return map_sym(((m_pos % 2) != 0) ? 2'b11 : 2'b00);
      return map_sym(pay_sym[m_pos - PRE]);
   endfunction

   // PRBS7 as a bit stream: b[n+7] = b[n] ^ b[n+1]; symbol k = {b[2k], b[2k+1]}.
   task automatic build_payload(input logic [6:0] seed);
      bit b [2*PAY+8];
      for (int n = 0; n < 7; n++) b[n] = seed[6-n];
      for (int n = 7; n < 2*PAY+8; n++) b[n] = b[n-7] ^ b[n-6];
      for (int k = 0; k < PAY; k++) pay_sym[k] = {b[2*k], b[2*k+1]};
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_armed = 1'b0; m_pos = 0;
   endtask

   task automatic model_edge(input logic srst, input logic rdy);
      if (srst) begin
         m_run = 1'b0; m_armed = 1'b1; m_pos = 0;
      end else if (!m_run) begin
         if (m_armed) begin m_run = 1'b1; m_pos = 0; end
      end else begin
         if (!e_valid() || rdy) m_pos++;
         if (m_pos == FRAME) m_pos = 0;
      end
   endtask

   // Drive inputs, advance the model and the DUT one edge, settle 1 time unit.
   task automatic clk_step(input logic srst, input logic rdy);
      slow_rst  = srst;
      sym_ready = rdy;
      model_edge(srst, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      g_rst = 1'b1; slow_rst = 1'b0; sym_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 g_rst = 1'b0;
      vectors++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset.valid got %b exp 0", sym_valid); end
      vectors++; if (sym_sof !== 1'b0) begin errors++; $display("FAIL reset.sof got %b exp 0", sym_sof); end
      vectors++; if (sym_data !== 2'b00) begin errors++; $display("FAIL reset.data got %b exp 00", sym_data); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b exp 0", busy); end
      clk_step(1'b1, 1'b1);
      repeat (7) clk_step(1'b0, 1'b1);
      vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL reset.pre_valid got %b exp %b", sym_valid, e_valid()); end
      #3 g_rst = 1'b1;
      #1;
      vectors++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset.async_valid got %b exp 0", sym_valid); end
      vectors++; if (sym_sof !== 1'b0) begin errors++; $display("FAIL reset.async_sof got %b exp 0", sym_sof); end
      vectors++; if (sym_data !== 2'b00) begin errors++; $display("FAIL reset.async_data got %b exp 00", sym_data); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.async_busy got %b exp 0", busy); end
      g_rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         clk_step(1'b0, 1'($urandom % 2));
         vectors++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL unarmed.valid cyc=%0d got %b exp 0", i, sym_valid); end
         vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL unarmed.busy cyc=%0d got %b exp 0", i, busy); end
      end
   endtask

   task automatic test_frame_start();
      for (int i = 0; i < 20; i++) begin
         clk_step(1'b1, 1'b1);
         vectors++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL start.held_valid cyc=%0d got %b exp 0", i, sym_valid); end
      end
      clk_step(1'b0, 1'b1);
      vectors++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL start.valid got %b exp 1", sym_valid); end
      vectors++; if (sym_sof !== 1'b1) begin errors++; $display("FAIL start.sof got %b exp 1", sym_sof); end
      vectors++; if (sym_data !== map_sym(2'b00)) begin errors++; $display("FAIL start.data got %b exp %b", sym_data, map_sym(2'b00)); end
      for (int i = 0; i < FRAME + PRE + 8; i++) begin
         clk_step(1'b0, 1'b1);
         vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL frame.valid pos=%0d got %b exp %b", m_pos, sym_valid, e_valid()); end
         vectors++; if (busy !== e_busy()) begin errors++; $display("FAIL frame.busy pos=%0d got %b exp %b", m_pos, busy, e_busy()); end
         vectors++; if (sym_sof !== e_sof()) begin errors++; $display("FAIL frame.sof pos=%0d got %b exp %b", m_pos, sym_sof, e_sof()); end
         if (e_valid()) begin
            vectors++; if (sym_data !== e_data()) begin errors++; $display("FAIL frame.data pos=%0d got %b exp %b", m_pos, sym_data, e_data()); end
         end
      end
   endtask

   task automatic test_payload();
      logic [1:0] first4 [4];
      int hits = 0;
      first4[0] = 2'b11; first4[1] = 2'b11; first4[2] = 2'b11; first4[3] = 2'b10;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (e_valid() && m_pos >= PRE && m_pos < PRE + 4) begin
            hits++;
            vectors++; if (sym_data !== map_sym(first4[m_pos - PRE])) begin errors++; $display("FAIL payload.first4 idx=%0d got %b exp %b", m_pos - PRE, sym_data, map_sym(first4[m_pos - PRE])); end
         end
         if (e_valid()) begin
            vectors++; if (sym_data !== e_data()) begin errors++; $display("FAIL payload.data pos=%0d got %b exp %b", m_pos, sym_data, e_data()); end
         end
         vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL payload.valid pos=%0d got %b exp %b", m_pos, sym_valid, e_valid()); end
         clk_step(1'b0, 1'b1);
      end
      vectors++; if (hits !== 8) begin errors++; $display("FAIL payload.frames_seen got %0d exp 8", hits); end
   endtask

   task automatic test_stall();
      logic       rdy;
      logic       stalled = 1'b0;
      logic [1:0] prev_data = 2'b00;
      logic       prev_sof = 1'b0;
      int         accepts = 0;
      int         gap_run = 0;
      int         frames = 0;
      for (int i = 0; i < 3 * FRAME * 2; i++) begin
         vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL stall.valid pos=%0d got %b exp %b", m_pos, sym_valid, e_valid()); end
         vectors++; if (busy !== e_busy()) begin errors++; $display("FAIL stall.busy pos=%0d got %b exp %b", m_pos, busy, e_busy()); end
         vectors++; if (sym_sof !== e_sof()) begin errors++; $display("FAIL stall.sof pos=%0d got %b exp %b", m_pos, sym_sof, e_sof()); end
         if (e_valid()) begin
            vectors++; if (sym_data !== e_data()) begin errors++; $display("FAIL stall.data pos=%0d got %b exp %b", m_pos, sym_data, e_data()); end
         end
         if (stalled) begin
            vectors++; if (sym_data !== prev_data || sym_sof !== prev_sof) begin errors++; $display("FAIL stall.hold got %b/%b exp %b/%b", sym_data, sym_sof, prev_data, prev_sof); end
         end
         if (busy && !sym_valid) gap_run++;
         if (sym_valid && gap_run > 0) begin
            vectors++; if (gap_run !== GAP) begin errors++; $display("FAIL stall.gap_len got %0d exp %0d", gap_run, GAP); end
            gap_run = 0;
         end
         rdy = 1'($urandom % 2);
         if (sym_valid && rdy) begin
            if (sym_sof) begin
               if (frames > 0) begin
                  vectors++; if (accepts !== PRE + PAY) begin errors++; $display("FAIL stall.accepts got %0d exp %0d", accepts, PRE + PAY); end
               end
               frames++;
               accepts = 0;
            end
            accepts++;
         end
         stalled   = sym_valid && !rdy;
         prev_data = sym_data;
         prev_sof  = sym_sof;
         clk_step(1'b0, rdy);
      end
      vectors++; if (frames < 2) begin errors++; $display("FAIL stall.frame_count got %0d exp >=2", frames); end
   endtask

   task automatic run_to_pos(input int target, input string tag);
      int n = 0;
      while (!(m_run && m_pos == target) && n < 2 * FRAME + 4) begin
         clk_step(1'b0, 1'b1);
         n++;
         vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL %s.run_valid pos=%0d got %b exp %b", tag, m_pos, sym_valid, e_valid()); end
      end
      vectors++; if (!(m_run && m_pos == target)) begin errors++; $display("FAIL %s.reach got pos %0d exp %0d", tag, m_pos, target); end
   endtask

   task automatic test_mid_slow_rst(input int target, input string tag);
      run_to_pos(target, tag);
      if (e_valid()) begin
         vectors++; if (sym_data !== e_data()) begin errors++; $display("FAIL %s.data_before got %b exp %b", tag, sym_data, e_data()); end
      end
      clk_step(1'b1, 1'b1);
      vectors++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL %s.idle_valid got %b exp 0", tag, sym_valid); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL %s.idle_busy got %b exp 0", tag, busy); end
      vectors++; if (sym_sof !== 1'b0) begin errors++; $display("FAIL %s.idle_sof got %b exp 0", tag, sym_sof); end
      clk_step(1'b0, 1'b1);
      vectors++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL %s.restart_valid got %b exp 1", tag, sym_valid); end
      vectors++; if (sym_sof !== 1'b1) begin errors++; $display("FAIL %s.restart_sof got %b exp 1", tag, sym_sof); end
      vectors++; if (sym_data !== map_sym(2'b00)) begin errors++; $display("FAIL %s.restart_data got %b exp %b", tag, sym_data, map_sym(2'b00)); end
      for (int i = 0; i < PRE + 6; i++) begin
         clk_step(1'b0, 1'($urandom % 2));
         vectors++; if (sym_valid !== e_valid()) begin errors++; $display("FAIL %s.after_valid pos=%0d got %b exp %b", tag, m_pos, sym_valid, e_valid()); end
         vectors++; if (sym_sof !== e_sof()) begin errors++; $display("FAIL %s.after_sof pos=%0d got %b exp %b", tag, m_pos, sym_sof, e_sof()); end
         if (e_valid()) begin
            vectors++; if (sym_data !== e_data()) begin errors++; $display("FAIL %s.after_data pos=%0d got %b exp %b", tag, m_pos, sym_data, e_data()); end
         end
      end
   endtask

   initial begin
      build_payload(7'h7F);
      test_reset();
      test_frame_start();
      test_payload();
      test_stall();
      test_mid_slow_rst(PRE + 100, "midpay");
      test_mid_slow_rst(PRE - 1, "lastpre");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
